bram_init_filler: RTL

BRAM_INIT_FILLER -- requirements
Module: bram_init_filler

---
 rtl/bram_init_filler_if.sv | 21 ++
 rtl/bram_init_filler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bram_init_filler_if.sv
// BRAM port-B bundle between the init filler (master) and the memory (slave).
interface bram_init_filler_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic              bram_we;
   logic              bram_en;
   logic [DATA_W-1:0] bram_dout;

   modport master (
      output bram_addr, bram_din, bram_we, bram_en,
      input  bram_dout
   );

   modport slave (
      input  bram_addr, bram_din, bram_we, bram_en,
      output bram_dout
   );
endinterface

// File: rtl/bram_init_filler.sv
// Fills a BRAM with a selectable pattern and optionally reads it back to count mismatches.
module bram_init_filler #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          pattern_sel,
   input  logic [DATA_W-1:0]   seed,
   input  logic                verify_en,
   input  logic                abort,
   bram_init_filler_if.master  bram,
   output logic                busy,
   output logic                done,
   output logic                err_flag,
   output logic [ADDR_W:0]     err_cnt,
   output logic [ADDR_W-1:0]   first_err_addr
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;

   logic [1:0]        sel_q;
   logic [DATA_W-1:0] seed_q;
   logic              verify_q;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              we_q, we_d;
   logic              en_q, en_d;
   logic              busy_d, done_d;
   logic              err_flag_d;
   logic [CNT_W-1:0]  err_cnt_d;
   logic [ADDR_W-1:0] first_err_d;

   logic [ADDR_W-1:0] rd_addr_q;
   logic              cmp_vld_q;

   logic              start_go;
   logic              mismatch;
   logic [1:0]        sel_eff;
   logic [DATA_W-1:0] seed_eff;

   // Pattern word for index idx: 01 constant, 10 inverted increment, 00/11 increment.
   function automatic logic [DATA_W-1:0] pattern_word(input logic [1:0]        sel,
                                                      input logic [DATA_W-1:0] base,
                                                      input logic [ADDR_W-1:0] idx);
      logic [DATA_W-1:0] sum;
      sum = base + DATA_W'(idx);
      case (sel)
         2'b01:   pattern_word = base;
         2'b10:   pattern_word = ~sum;
         default: pattern_word = sum;
      endcase
   endfunction

   // Start qualification, and pattern controls seen by the first write (not yet latched).
   always_comb begin
      start_go = (state_q == S_IDLE) && start;
      sel_eff  = start_go ? pattern_sel : sel_q;
      seed_eff = start_go ? seed : seed_q;
      mismatch = cmp_vld_q && !abort &&
                 (bram.bram_dout != pattern_word(sel_q, seed_q, rd_addr_q));
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic; abort cancels any active pass.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_WRITE;
         S_WRITE: begin
            if (abort)                   state_d = S_IDLE;
            else if (addr_q == LAST_ADDR) state_d = verify_q ? S_READ : S_DONE;
         end
         S_READ: begin
            if (abort)                   state_d = S_IDLE;
            else if (addr_q == LAST_ADDR) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = abort ? S_IDLE : S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs, derived from the state being entered.
   always_comb begin
      addr_d      = '0;
      din_d       = '0;
      we_d        = 1'b0;
      en_d        = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_flag_d  = err_flag;
      err_cnt_d   = err_cnt;
      first_err_d = first_err_addr;

      case (state_d)
         S_WRITE: begin
            en_d   = 1'b1;
            we_d   = 1'b1;
            busy_d = 1'b1;
            addr_d = (state_q == S_WRITE) ? addr_q + ADDR_W'(1) : '0;
            din_d  = pattern_word(sel_eff, seed_eff, addr_d);
         end
         S_READ: begin
            en_d   = 1'b1;
            busy_d = 1'b1;
            addr_d = (state_q == S_READ) ? addr_q + ADDR_W'(1) : '0;
         end
         S_DRAIN: busy_d = 1'b1;
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase

      if (start_go) begin
         err_flag_d  = 1'b0;
         err_cnt_d   = '0;
         first_err_d = '0;
      end else if (mismatch) begin
         err_flag_d = 1'b1;
         err_cnt_d  = err_cnt + CNT_W'(1);
         if (!err_flag) first_err_d = rd_addr_q;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q         <= '0;
         din_q          <= '0;
         we_q           <= 1'b0;
         en_q           <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_flag       <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
      end else begin
         addr_q         <= addr_d;
         din_q          <= din_d;
         we_q           <= we_d;
         en_q           <= en_d;
         busy           <= busy_d;
         done           <= done_d;
         err_flag       <= err_flag_d;
         err_cnt        <= err_cnt_d;
         first_err_addr <= first_err_d;
      end
   end

   // Pass configuration captured when a start is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_q    <= '0;
         seed_q   <= '0;
         verify_q <= 1'b0;
      end else if (start_go) begin
         sel_q    <= pattern_sel;
         seed_q   <= seed;
         verify_q <= verify_en;
      end
   end

   // Readback pipeline: remember the issued read address until its data returns.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr_q <= '0;
         cmp_vld_q <= 1'b0;
      end else begin
         rd_addr_q <= addr_q;
         cmp_vld_q <= (state_q == S_READ) && !abort;
      end
   end

   assign bram.bram_addr = addr_q;
   assign bram.bram_din  = din_q;
   assign bram.bram_we   = we_q;
   assign bram.bram_en   = en_q;

endmodule
